xeng_corr_apply: RTL and testbench

XENG_CORR_APPLY -- requirements
Module: xeng_corr_apply

---
 rtl/xeng_corr_apply.sv | 137 +++++++++++++
 tb/tb_xeng_corr_apply.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/xeng_corr_apply.sv
// X-engine correction apply: subtracts a per-baseline correction, taken from
// a small FIFO, from each X-engine accumulator output. Two-cycle latency.
//
// Handshake: xeng_vld and corr_vld are single-cycle qualifiers with no
// backpressure. A beat is taken on every rising edge where its valid is 1.
// dout_vld marks each result exactly two cycles after its xeng_vld.
module xeng_corr_apply #(
  parameter int ACC_WIDTH       = 16,
  parameter int CORR_WIDTH      = 14,
  parameter int FIFO_DEPTH_BITS = 2,
  localparam int OUT_WIDTH      = ACC_WIDTH + 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       sync_in,
  input  logic [8*ACC_WIDTH-1:0]     xeng_din,
  input  logic                       xeng_vld,
  input  logic [8*CORR_WIDTH-1:0]    corr_din,
  input  logic                       corr_vld,
  output logic [8*OUT_WIDTH-1:0]     dout,
  output logic                       dout_vld,
  output logic                       sync_out,
  output logic [FIFO_DEPTH_BITS:0]   fifo_level,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int DEPTH = 1 << FIFO_DEPTH_BITS;
  localparam int LW    = FIFO_DEPTH_BITS + 1;

  // A correction wider than the accumulator cannot be sign-extended into it.
  if (CORR_WIDTH > ACC_WIDTH) begin : g_cfg_err
    $error("xeng_corr_apply: CORR_WIDTH must not exceed ACC_WIDTH");
  end

  logic [8*CORR_WIDTH-1:0]    mem [DEPTH];
  logic [FIFO_DEPTH_BITS-1:0] wr_ptr;
  logic [FIFO_DEPTH_BITS-1:0] rd_ptr;
  logic [FIFO_DEPTH_BITS-1:0] wr_addr;
  logic                       fifo_full;
  logic                       fifo_empty;
  logic                       pop;
  logic                       push;
  logic                       drop;
  logic [8*CORR_WIDTH-1:0]    head;

  // Stage 1 registers: baseline and its selected correction.
  logic                       v1;
  logic                       s1;
  logic [8*ACC_WIDTH-1:0]     x1;
  logic [8*CORR_WIDTH-1:0]    c1;
  logic [8*OUT_WIDTH-1:0]     dout_next;

  // FIFO control. A pop sees only entries present before this cycle (no
  // bypass). A flush empties the FIFO before this cycle's push, so the push
  // always lands and the pop still uses the pre-flush head.
  always_comb begin
    fifo_full  = (fifo_level == LW'(DEPTH));
    fifo_empty = (fifo_level == '0);
    pop        = xeng_vld & ~fifo_empty;
    push       = corr_vld & (sync_in | ~fifo_full | pop);
    drop       = corr_vld & ~push;
    wr_addr    = sync_in ? '0 : wr_ptr;
    head       = mem[rd_ptr];
  end

  // FIFO pointers, occupancy and sticky error flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      if (sync_in) begin
        rd_ptr     <= '0;
        wr_ptr     <= FIFO_DEPTH_BITS'(push);
        fifo_level <= LW'(push);
      end else begin
        rd_ptr     <= rd_ptr + FIFO_DEPTH_BITS'(pop);
        wr_ptr     <= wr_ptr + FIFO_DEPTH_BITS'(push);
        fifo_level <= fifo_level + LW'(push) - LW'(pop);
      end
      overflow  <= overflow | drop;
      underflow <= underflow | (xeng_vld & fifo_empty);
    end
  end

  // Correction storage; contents need no reset since occupancy guards reads.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem[wr_addr] <= corr_din;
    end
  end

  // Stage 1: capture baseline with its correction (zero when none available).
  always_ff @(posedge clk) begin
    if (rst) begin
      v1 <= 1'b0;
      s1 <= 1'b0;
      x1 <= '0;
      c1 <= '0;
    end else begin
      v1 <= xeng_vld;
      s1 <= sync_in;
      x1 <= xeng_din;
      c1 <= pop ? head : '0;
    end
  end

  // Per-component signed subtract at full output width; no saturation.
  always_comb begin
    dout_next = '0;
    for (int i = 0; i < 8; i++) begin
      dout_next[i*OUT_WIDTH +: OUT_WIDTH] =
        OUT_WIDTH'($signed(x1[i*ACC_WIDTH +: ACC_WIDTH])) -
        OUT_WIDTH'($signed(c1[i*CORR_WIDTH +: CORR_WIDTH]));
    end
  end

  // Stage 2: register result; dout holds its last value between results.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout     <= '0;
      dout_vld <= 1'b0;
      sync_out <= 1'b0;
    end else begin
      dout_vld <= v1;
      sync_out <= s1;
      if (v1) begin
        dout <= dout_next;
      end
    end
  end

endmodule

// File: tb/tb_xeng_corr_apply.sv
// Directed and random bench for xeng_corr_apply with a correction-FIFO model
// and a scoreboard of expected results and their due cycles.
module tb_xeng_corr_apply;

  localparam int W     = 16;
  localparam int CW    = 14;
  localparam int DB    = 2;
  localparam int OW    = W + 1;
  localparam int DEPTH = 1 << DB;

  logic              clk;
  logic              rst;
  logic              sync_in;
  logic [8*W-1:0]    xeng_din;
  logic              xeng_vld;
  logic [8*CW-1:0]   corr_din;
  logic              corr_vld;
  logic [8*OW-1:0]   dout;
  logic              dout_vld;
  logic              sync_out;
  logic [DB:0]       fifo_level;
  logic              overflow;
  logic              underflow;

  xeng_corr_apply #(
    .ACC_WIDTH(W), .CORR_WIDTH(CW), .FIFO_DEPTH_BITS(DB)
  ) dut (
    .clk(clk), .rst(rst), .sync_in(sync_in),
    .xeng_din(xeng_din), .xeng_vld(xeng_vld),
    .corr_din(corr_din), .corr_vld(corr_vld),
    .dout(dout), .dout_vld(dout_vld), .sync_out(sync_out),
    .fifo_level(fifo_level), .overflow(overflow), .underflow(underflow)
  );

  // Clock and cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard and model state
  logic [8*OW-1:0] exp_q[$];
  int              t_q[$];
  logic [8*CW-1:0] cq[$];
  bit              m_ovf = 1'b0;
  bit              m_udf = 1'b0;
  bit [1:0]        sh = 2'b00;
  logic [8*OW-1:0] last_dout = '0;
  int              vectors = 0;
  int              miscompares = 0;

  function automatic logic [8*W-1:0] rep_x(input int v);
    return {8{W'(v)}};
  endfunction

  function automatic logic [8*CW-1:0] rep_c(input int v);
    return {8{CW'(v)}};
  endfunction

  function automatic logic [8*OW-1:0] exp_dout(input logic [8*W-1:0] x,
                                               input logic [8*CW-1:0] c);
    logic [8*OW-1:0] r;
    int xs, cs, d;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      xs = $signed(x[i*W +: W]);
      cs = $signed(c[i*CW +: CW]);
      d  = xs - cs;
      r[i*OW +: OW] = d[OW-1:0];
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [135:0] obs,
                       input logic [135:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, "_level"}, 136'(fifo_level), 136'(cq.size()));
    check({tag, "_ovf"}, 136'(overflow), 136'(m_ovf));
    check({tag, "_udf"}, 136'(underflow), 136'(m_udf));
  endtask

  // Driver: applies one cycle of inputs and advances the reference model.
  task automatic drive(input bit s, input bit xv, input logic [8*W-1:0] x,
                       input bit cv, input logic [8*CW-1:0] c);
    logic [8*CW-1:0] h;
    h = '0;
    sync_in = s; xeng_vld = xv; xeng_din = x; corr_vld = cv; corr_din = c;
    if (xv) begin
      if (cq.size() > 0) h = cq.pop_front();
      else m_udf = 1'b1;
      exp_q.push_back(exp_dout(x, h));
      t_q.push_back(cyc + 2);
    end
    if (s) cq.delete();
    if (cv) begin
      if (cq.size() < DEPTH) cq.push_back(c);
      else m_ovf = 1'b1;
    end
    @(posedge clk); #1;
    sync_in = 1'b0; xeng_vld = 1'b0; corr_vld = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, '0, 1'b0, '0);
  endtask

  // sync_out reference: sync_in delayed two cycles, cleared by reset
  always @(posedge clk) begin
    if (rst) sh <= 2'b00;
    else     sh <= {sh[0], sync_in};
  end

  // Monitor: compares outputs on the falling edge
  always @(negedge clk) begin
    vectors++;
    assert (sync_out === sh[1]) else begin
      miscompares++;
      $error("FAIL sync_out observed=%0b expected=%0b", sync_out, sh[1]);
    end
    if (rst) begin
      last_dout = '0;
    end else begin
      if (t_q.size() > 0 && cyc >= t_q[0]) begin
        vectors++;
        assert (dout_vld === 1'b1) else begin
          miscompares++;
          $error("FAIL dout_vld_missing observed=%0b expected=1", dout_vld);
        end
        if (dout_vld !== 1'b1) begin
          void'(exp_q.pop_front());
          void'(t_q.pop_front());
        end
      end
      if (dout_vld === 1'b1) begin
        vectors++;
        assert (exp_q.size() > 0) else begin
          miscompares++;
          $error("FAIL dout_vld_spurious observed=1 expected=0");
        end
        if (exp_q.size() > 0) begin
          vectors++;
          assert (dout === exp_q[0]) else begin
            miscompares++;
            $error("FAIL dout observed=%0h expected=%0h", dout, exp_q[0]);
          end
          vectors++;
          assert (cyc === t_q[0]) else begin
            miscompares++;
            $error("FAIL latency observed=%0d expected=%0d", cyc, t_q[0]);
          end
          void'(exp_q.pop_front());
          void'(t_q.pop_front());
        end
        last_dout = dout;
      end else begin
        vectors++;
        assert (dout === last_dout) else begin
          miscompares++;
          $error("FAIL dout_hold observed=%0h expected=%0h", dout, last_dout);
        end
      end
    end
  end

  initial begin
    logic [8*W-1:0]  x;
    logic [8*CW-1:0] c;
    rst = 1'b1; sync_in = 1'b0; xeng_vld = 1'b0; xeng_din = '0;
    corr_vld = 1'b0; corr_din = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_dout", 136'(dout), 136'(0));
    check("rst_dout_vld", 136'(dout_vld), 136'(0));
    check("rst_level", 136'(fifo_level), 136'(0));
    check("rst_ovf", 136'(overflow), 136'(0));
    check("rst_udf", 136'(underflow), 136'(0));
    rst = 1'b0;
    idle(2);

    // Basic: correction 5 applied to baseline 100 -> 95
    drive(1'b0, 1'b0, '0, 1'b1, rep_c(5));
    check("basic_level_push", 136'(fifo_level), 136'(1));
    drive(1'b0, 1'b1, rep_x(100), 1'b0, '0);
    check_state("basic_pop");
    @(posedge clk); #1;
    check("basic_dout", 136'(dout), 136'({8{17'd95}}));
    check("basic_vld", 136'(dout_vld), 136'(1));
    idle(2);

    // Sign and extremes
    x = rep_x(3); x[7*W +: W] = W'(-10); x[0 +: W] = W'(32767);
    c = rep_c(1); c[7*CW +: CW] = CW'(20); c[0 +: CW] = CW'(-8192);
    drive(1'b0, 1'b0, '0, 1'b1, c);
    drive(1'b0, 1'b1, x, 1'b0, '0);
    @(posedge clk); #1;
    check("sign_re_xx", 136'(dout[7*OW +: OW]), 136'(17'h1ffe2));
    check("sign_im_yy", 136'(dout[0 +: OW]), 136'(17'd40959));
    idle(2);

    // Overflow: five pushes into a four-deep FIFO, then four ordered pops
    for (int v = 1; v <= 5; v++) drive(1'b0, 1'b0, '0, 1'b1, rep_c(v));
    check("ovf_level", 136'(fifo_level), 136'(4));
    check("ovf_flag", 136'(overflow), 136'(1));
    for (int v = 1; v <= 4; v++) begin
      drive(1'b0, 1'b1, rep_x(50), 1'b0, '0);
      check_state("ovf_pop");
    end
    idle(3);

    // Underflow: empty FIFO gives zero correction; flag survives sync_in
    drive(1'b0, 1'b1, rep_x(7), 1'b0, '0);
    check("udf_flag", 136'(underflow), 136'(1));
    idle(2);
    drive(1'b1, 1'b0, '0, 1'b0, '0);
    check("udf_after_sync", 136'(underflow), 136'(1));
    idle(3);

    // Flush with same-cycle pop and push
    drive(1'b0, 1'b0, '0, 1'b1, rep_c(11));
    drive(1'b0, 1'b0, '0, 1'b1, rep_c(12));
    drive(1'b0, 1'b0, '0, 1'b1, rep_c(13));
    check("flush_pre_level", 136'(fifo_level), 136'(3));
    drive(1'b1, 1'b1, rep_x(100), 1'b1, rep_c(21));
    check("flush_level", 136'(fifo_level), 136'(1));
    drive(1'b0, 1'b1, rep_x(100), 1'b0, '0);
    check_state("flush_after");
    idle(3);

    // Random traffic
    for (int i = 0; i < 60; i++) begin
      x = {$urandom(), $urandom(), $urandom(), $urandom()};
      c = 112'({$urandom(), $urandom(), $urandom(), $urandom()});
      drive(($urandom_range(0, 9) == 0), 1'($urandom_range(0, 1)), x,
            1'($urandom_range(0, 1)), c);
      check_state("rand");
    end
    idle(3);

    // Reset one cycle after a baseline: result cancelled, inputs discarded
    drive(1'b0, 1'b1, rep_x(9), 1'b1, rep_c(4));
    void'(exp_q.pop_back());
    void'(t_q.pop_back());
    cq.delete(); m_ovf = 1'b0; m_udf = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    sync_in = 1'b1; xeng_vld = 1'b1; corr_vld = 1'b1;
    xeng_din = rep_x(1); corr_din = rep_c(1);
    @(posedge clk); #1;
    sync_in = 1'b0; xeng_vld = 1'b0; corr_vld = 1'b0;
    check("rstmid_dout", 136'(dout), 136'(0));
    check("rstmid_vld", 136'(dout_vld), 136'(0));
    check("rstmid_sync", 136'(sync_out), 136'(0));
    rst = 1'b0;
    check_state("rstmid");
    idle(4);
    check_state("post_rst");

    drive(1'b0, 1'b0, '0, 1'b1, rep_c(2));
    drive(1'b0, 1'b1, rep_x(10), 1'b0, '0);
    idle(4);
    check("drained", 136'(exp_q.size()), 136'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
